// File: rtl/alu_ctrl_pipe_if.sv
// ID/EX control bus between the instruction decode stage and alu_ctrl_pipe.
interface alu_ctrl_pipe_if #(
  parameter int CTRL_W = 6
);
  logic [5:0]        OP;
  logic [5:0]        Func;
  logic              in_valid;
  logic              stall_in;
  logic              flush;
  logic [CTRL_W-1:0] ALUControl_q;
  logic              out_valid;
  logic              mul_busy;
  logic              stall_req;

  // Upstream side: presents the instruction and observes the registered control word
  modport master (
    output OP, Func, in_valid, stall_in, flush,
    input  ALUControl_q, out_valid, mul_busy, stall_req
  );

  // Decoder side
  modport slave (
    input  OP, Func, in_valid, stall_in, flush,
    output ALUControl_q, out_valid, mul_busy, stall_req
  );
endinterface

// File: rtl/alu_ctrl_pipe.sv
// alu_ctrl_pipe: decodes OP/Func into an ALU control word, registers it into
// the ID/EX boundary and stalls HI/LO users while a multiply is in flight.
module alu_ctrl_pipe #(
  parameter int CTRL_W  = 6,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = $clog2(MUL_LAT + 1)
) (
  input  logic           Clk,
  input  logic           Rst,
  alu_ctrl_pipe_if.slave bus
);

  logic [5:0]        w_dec;
  logic              w_mul_op;
  logic              w_hilo_mv;
  logic              w_hilo_op;
  logic              w_stall_req;
  logic              w_accept;
  logic              w_busy;
  logic [CTRL_W-1:0] r_ctrl_q;
  logic              r_valid_q;
  logic [CNT_W-1:0]  r_cnt;

  // Combinational decode of OP/Func plus multiply and HI/LO classification
  always_comb begin
    w_dec     = 6'b000000;
    w_mul_op  = 1'b0;
    w_hilo_mv = 1'b0;
    case (bus.OP)
      6'b000000: begin
        case (bus.Func)
          6'b100000: w_dec = 6'b000001;                          // add
          6'b100001: w_dec = 6'b100011;                          // addu
          6'b100010: w_dec = 6'b000011;                          // sub
          6'b100100: w_dec = 6'b000101;                          // and
          6'b100101: w_dec = 6'b000111;                          // or
          6'b100111: w_dec = 6'b001001;                          // nor
          6'b100110: w_dec = 6'b001011;                          // xor
          6'b101010: w_dec = 6'b001101;                          // slt
          6'b101011: w_dec = 6'b100001;                          // sltu
          6'b011000: begin w_dec = 6'b001111; w_mul_op = 1'b1; end   // mult
          6'b011001: begin w_dec = 6'b010001; w_mul_op = 1'b1; end   // multu
          6'b001011: w_dec = 6'b010011;                          // movn
          6'b001010: w_dec = 6'b010101;                          // movz
          6'b000000, 6'b000100: w_dec = 6'b010111;               // sll / sllv
          6'b000010: w_dec = 6'b011001;                          // srl
          6'b000110: w_dec = 6'b011011;                          // srlv
          6'b000011, 6'b000111: w_dec = 6'b011101;               // sra / srav
          6'b010001: begin w_dec = 6'b111000; w_hilo_mv = 1'b1; end  // mthi
          6'b010011: begin w_dec = 6'b111001; w_hilo_mv = 1'b1; end  // mtlo
          6'b010000: begin w_dec = 6'b101010; w_hilo_mv = 1'b1; end  // mfhi
          6'b010010: begin w_dec = 6'b100010; w_hilo_mv = 1'b1; end  // mflo
          default:   w_dec = 6'b000000;
        endcase
      end
      6'b100011, 6'b101011, 6'b100000, 6'b100001,
      6'b101000, 6'b101001, 6'b001000: w_dec = 6'b000001;        // loads/stores, addi
      6'b001001: w_dec = 6'b100011;                              // addiu
      6'b001111: w_dec = 6'b000010;                              // lui
      6'b000001: w_dec = 6'b110000;                              // REGIMM
      6'b000100: w_dec = 6'b110001;                              // beq
      6'b000101: w_dec = 6'b110010;                              // bne
      6'b000111: w_dec = 6'b110011;                              // bgtz
      6'b000110: w_dec = 6'b110100;                              // blez
      6'b001101: w_dec = 6'b100111;                              // ori
      6'b001110: w_dec = 6'b111010;                              // xori
      6'b001100: w_dec = 6'b111011;                              // andi
      6'b001010: w_dec = 6'b001101;                              // slti
      6'b001011: w_dec = 6'b100001;                              // sltiu
      6'b011111: w_dec = 6'b011111;                              // SPECIAL3
      6'b011100: begin                                           // SPECIAL2
        if (bus.Func == 6'b000000 || bus.Func == 6'b000010 || bus.Func == 6'b000100) begin
          w_dec    = 6'b001111;                                  // madd / mul / msub
          w_mul_op = 1'b1;
        end
      end
      default: w_dec = 6'b000000;
    endcase
  end

  // Any multiply also touches HI/LO, so it must wait for a running one
  assign w_hilo_op   = w_hilo_mv | w_mul_op;
  assign w_busy      = (r_cnt != '0);
  assign w_stall_req = bus.in_valid & ~bus.flush & w_hilo_op & w_busy;
  assign w_accept    = bus.in_valid & ~bus.flush & ~w_stall_req & ~bus.stall_in;

  // ID/EX output register: downstream hold wins, then accept, otherwise a bubble
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_ctrl_q  <= '0;
      r_valid_q <= 1'b0;
    end else if (bus.stall_in) begin
      r_ctrl_q  <= r_ctrl_q;
      r_valid_q <= r_valid_q;
    end else if (w_accept) begin
      r_ctrl_q  <= CTRL_W'(w_dec);
      r_valid_q <= 1'b1;
    end else begin
      r_ctrl_q  <= '0;
      r_valid_q <= 1'b0;
    end
  end

  // Multiplier busy counter: loads on an accepted multiply and free-runs down,
  // ignoring stall_in and flush; with MUL_LAT=1 the load value is 0
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_cnt <= '0;
    end else if (w_accept && w_mul_op) begin
      r_cnt <= CNT_W'(MUL_LAT - 1);
    end else if (w_busy) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign bus.ALUControl_q = r_ctrl_q;
  assign bus.out_valid    = r_valid_q;
  assign bus.mul_busy     = w_busy;
  assign bus.stall_req    = w_stall_req;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Directed bench for alu_ctrl_pipe: u0 uses MUL_LAT=4/CTRL_W=6, u1 uses
// MUL_LAT=1/CTRL_W=8 and sees the same stimulus.
module tb_alu_ctrl_pipe;

  logic Clk;
  logic Rst;
  int   checks;
  int   errors;

  alu_ctrl_pipe_if #(.CTRL_W(6)) bus0 ();
  alu_ctrl_pipe_if #(.CTRL_W(8)) bus1 ();

  alu_ctrl_pipe #(.CTRL_W(6), .MUL_LAT(4)) u0 (.Clk(Clk), .Rst(Rst), .bus(bus0));
  alu_ctrl_pipe #(.CTRL_W(8), .MUL_LAT(1)) u1 (.Clk(Clk), .Rst(Rst), .bus(bus1));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                       input logic v, input logic s, input logic f);
    bus0.OP = op; bus0.Func = fn; bus0.in_valid = v; bus0.stall_in = s; bus0.flush = f;
    bus1.OP = op; bus1.Func = fn; bus1.in_valid = v; bus1.stall_in = s; bus1.flush = f;
  endtask

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic chk0(input string tag, input logic [5:0] ctrl, input logic ov, input logic busy);
    chk({tag, "_ctrl"}, 32'(bus0.ALUControl_q), 32'(ctrl));
    chk({tag, "_ov"},   32'(bus0.out_valid),    32'(ov));
    chk({tag, "_busy"}, 32'(bus0.mul_busy),     32'(busy));
    $display("step %-10s ctrl=%b ov=%b busy=%b stall=%b", tag, bus0.ALUControl_q,
             bus0.out_valid, bus0.mul_busy, bus0.stall_req);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    Rst = 1'b1;
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    #12;
    chk0("reset", 6'b000000, 1'b0, 1'b0);
    chk("reset_u1_ov", 32'(bus1.out_valid), 32'd0);
    Rst = 1'b0;

    // Basic decode
    drive(6'b000000, 6'b100010, 1'b1, 1'b0, 1'b0); tick();            // sub
    chk0("sub", 6'b000011, 1'b1, 1'b0);
    drive(6'b001110, 6'b000000, 1'b1, 1'b0, 1'b0); tick();            // xori
    chk0("xori", 6'b111010, 1'b1, 1'b0);
    drive(6'b111111, 6'b000000, 1'b1, 1'b0, 1'b0); tick();            // unlisted
    chk0("unlisted", 6'b000000, 1'b1, 1'b0);
    drive(6'b000000, 6'b100000, 1'b1, 1'b0, 1'b0); tick();            // add
    chk0("add", 6'b000001, 1'b1, 1'b0);
    chk("add_w8", 32'(bus1.ALUControl_q), 32'h01);

    // mult then mflo: 3 stall cycles
    drive(6'b000000, 6'b011000, 1'b1, 1'b0, 1'b0); #1;
    chk("mult_nostall", 32'(bus0.stall_req), 32'd0);
    tick();
    chk0("mult", 6'b001111, 1'b1, 1'b1);
    chk("mult_u1_busy", 32'(bus1.mul_busy), 32'd0);
    drive(6'b000000, 6'b010010, 1'b1, 1'b0, 1'b0);                     // mflo
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("mflo_stall", 32'(bus0.stall_req), 32'd1);
      chk("mflo_busy", 32'(bus0.mul_busy), 32'd1);
      chk("u1_nostall", 32'(bus1.stall_req), 32'd0);
      tick();
      chk("mflo_bubble", 32'(bus0.out_valid), 32'd0);
      if (k == 0) chk("u1_mflo", 32'(bus1.ALUControl_q), 32'h22);
    end
    #1;
    chk("mflo_free", 32'(bus0.stall_req), 32'd0);
    tick();
    chk0("mflo", 6'b100010, 1'b1, 1'b0);

    // madd then multu: multu waits 3 cycles then reloads the counter
    drive(6'b011100, 6'b000000, 1'b1, 1'b0, 1'b0); tick();
    chk0("madd", 6'b001111, 1'b1, 1'b1);
    drive(6'b000000, 6'b011001, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("multu_stall", 32'(bus0.stall_req), 32'd1);
      tick();
    end
    #1;
    chk("multu_free", 32'(bus0.stall_req), 32'd0);
    tick();
    chk0("multu", 6'b010001, 1'b1, 1'b1);

    // add, then hold for 2 cycles while the counter runs down (3 -> 2 -> 1 -> 0)
    drive(6'b000000, 6'b100000, 1'b1, 1'b0, 1'b0); tick();
    chk0("add2", 6'b000001, 1'b1, 1'b1);
    drive(6'b001110, 6'b000000, 1'b1, 1'b1, 1'b0); tick();
    chk0("hold1", 6'b000001, 1'b1, 1'b1);
    tick();
    chk0("hold2", 6'b000001, 1'b1, 1'b0);

    // Flush during a running multiply
    drive(6'b000000, 6'b011000, 1'b1, 1'b0, 1'b0); tick();
    chk0("mult2", 6'b001111, 1'b1, 1'b1);
    drive(6'b000000, 6'b010010, 1'b1, 1'b0, 1'b1); #1;                // flushed mflo
    chk("flush_nostall", 32'(bus0.stall_req), 32'd0);
    tick();
    chk0("flush_mflo", 6'b000000, 1'b0, 1'b1);
    drive(6'b000100, 6'b000000, 1'b1, 1'b0, 1'b1); tick();            // flushed beq
    chk0("flush_beq", 6'b000000, 1'b0, 1'b1);
    drive(6'b000100, 6'b000000, 1'b1, 1'b0, 1'b0); tick();            // beq, counter 1 -> 0
    chk0("beq", 6'b110001, 1'b1, 1'b0);

    // Asynchronous reset with counter=2 and a stalled mflo
    drive(6'b000000, 6'b011000, 1'b1, 1'b0, 1'b0); tick();
    drive(6'b000000, 6'b100000, 1'b1, 1'b0, 1'b0); tick();
    chk0("pre_rst", 6'b000001, 1'b1, 1'b1);
    drive(6'b000000, 6'b010010, 1'b1, 1'b0, 1'b0); #1;
    chk("pre_rst_stall", 32'(bus0.stall_req), 32'd1);
    #1 Rst = 1'b1;
    #1;
    chk0("async_rst", 6'b000000, 1'b0, 1'b0);
    chk("async_rst_stall", 32'(bus0.stall_req), 32'd0);
    #1 Rst = 1'b0;
    tick();
    chk0("post_rst", 6'b100010, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_pipe.md
Name: alu_ctrl_pipe

Overview:
- Parametrised, registered successor to the combinational ALU-control decoder.
- Decodes OP/Func into an ALU control word and registers it into the ID/EX boundary, with valid, stall and flush control.
- Tracks in-flight multi-cycle multiply operations on HI/LO. Raises a hazard stall when a HI/LO consumer or another multiply arrives while the multiplier is busy.

Parameters:
- CTRL_W, 6, width of the ALU control word; must be >= 6; decoded codes are zero-extended.
- MUL_LAT, 4, multiplier latency in cycles; must be >= 1.
- CNT_W, $clog2(MUL_LAT+1), width of the busy counter (derived).

Ports:
- Clk  input  1  clock, rising edge.
- Rst  input  1  asynchronous, active-high reset.
- OP  input  6  instruction opcode (ID stage).
- Func  input  6  instruction function field.
- in_valid  input  1  ID-stage instruction valid.
- stall_in  input  1  downstream hold; output register keeps its value.
- flush  input  1  kill the ID-stage instruction; insert a bubble.
- ALUControl_q  output  CTRL_W  registered ALU control word to EX.
- out_valid  output  1  ALUControl_q holds a real instruction.
- mul_busy  output  1  multiplier occupied (counter != 0).
- stall_req  output  1  combinational hazard stall to the PC/IF-ID registers.

Behaviour:
- Clock and reset: one clock, Clk. Reset Rst is asynchronous and active-high. On reset, ALUControl_q=0, out_valid=0, counter=0, mul_busy=0.
- Decode (combinational, 6-bit, zero-extended to CTRL_W); unlisted encodings decode to 0.
  - OP=000000, by Func:
    - add 000001; addu 100011; sub 000011; and 000101; or 000111; nor 001001; xor 001011
    - slt 001101; sltu 100001
    - mult 001111; multu 010001
    - movn 010011; movz 010101
    - sll/sllv 010111; srl 011001; srlv 011011; sra/srav 011101
    - mthi 111000; mtlo 111001; mfhi 101010; mflo 100010
  - Other opcodes:
    - lw/sw/lb/lh/sb/sh/addi 000001; addiu 100011; lui 000010
    - REGIMM 110000; beq 110001; bne 110010; bgtz 110011; blez 110100
    - ori 100111; xori 111010; andi 111011; slti 001101; sltiu 100001
    - OP=011111 -> 011111
    - OP=011100 with Func madd 000000 / mul 000010 / msub 000100 -> 001111
- Multiply class (mul_op): mult, multu, madd, msub, mul.
- HI/LO class (hilo_op): mfhi, mflo, mthi, mtlo, plus any mul_op.
- stall_req = in_valid & ~flush & hilo_op & mul_busy.
- accept = in_valid & ~flush & ~stall_req & ~stall_in.
- Output register, per rising edge, in priority order:
  1. If stall_in: hold ALUControl_q and out_valid.
  2. Else if accept: ALUControl_q <= decode; out_valid <= 1.
  3. Else: bubble, ALUControl_q <= 0, out_valid <= 0.
- Flush with stall_in=1: hold has priority (the flushed instruction never enters).
- Busy counter:
  - If accept & mul_op: counter <= MUL_LAT-1. A new multiply is only accepted when not busy, so there is no overlap.
  - Else if counter != 0: counter decrements by 1 every cycle, including during stall_in.
  - mul_busy = (counter != 0), registered-state derived.
  - MUL_LAT=1: counter stays 0, mul_busy never asserts, no stall is ever raised.
- Flush does not cancel an in-flight multiply; the counter keeps running.
- Latency: ID inputs to ALUControl_q is 1 cycle. A HI/LO consumer following a multiply by one cycle stalls for exactly MUL_LAT-1 cycles.
- Reset mid-operation (async): the counter clears immediately, stall_req drops in the same cycle, and the output becomes a bubble.

Test Plan:
- Reset/basic decode: Rst pulse, then OP=000000 Func=100010 in_valid=1 -> next cycle ALUControl_q=000011, out_valid=1. OP=001110 -> 111010. OP=111111 -> 0 with out_valid=1.
- Multiply hazard, MUL_LAT=4: mult accepted at cycle t. mflo presented at t+1 -> stall_req=1 for cycles t+1..t+3, mul_busy=1 over the same span. mflo is accepted at t+4 -> ALUControl_q=100010.
- Back-to-back multiply: madd (011100/000000) then multu -> multu stalls 3 cycles, then is accepted (010001) and the counter reloads to 3.
- stall_in hold: assert stall_in for 2 cycles after add -> ALUControl_q stays 000001. Counter started by a prior mult still decrements across the hold.
- Flush: flush=1 with beq in_valid -> next cycle ALUControl_q=0, out_valid=0. flush during mul_busy -> counter unaffected and stall_req=0.
- Async reset mid-busy: assert Rst between clock edges with counter=2 -> mul_busy, stall_req, out_valid go 0 immediately. CTRL_W=8 run: add -> 00000001.
